// File: rtl/config_stream_loader_pkg.sv
// Shared types and constants for the configuration stream loader and the tile address matchers.
package config_stream_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_ADDR,
        ST_DATA,
        ST_EMIT,
        ST_CHECK
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam int CFG_ADDR_WIDTH = 32;
    localparam int CFG_DATA_WIDTH = 32;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

    localparam int CFG_AB = bytes_of(CFG_ADDR_WIDTH);
    localparam int CFG_DB = bytes_of(CFG_DATA_WIDTH);

endpackage

// File: rtl/config_stream_loader_stream_byte_shifter.sv
// Little-endian byte assembler: each shifted byte enters at the top, so the first byte ends in [7:0].
// Latency: o_word already includes the byte being shifted this cycle.
// Backpressure: none; the caller qualifies i_shift with its own handshake.
module stream_byte_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_shift,
    input  logic             i_clear,
    input  logic [7:0]       i_byte,
    output logic [WIDTH-1:0] o_word,
    output logic             o_last
);

    localparam int NBYTES = WIDTH / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [WIDTH-1:0] r_word;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (NBYTES == 1) begin : g_single
            assign w_shifted = i_byte;
        end else begin : g_multi
            assign w_shifted = {i_byte, r_word[WIDTH-1:8]};
        end
    endgenerate

    // Look-through output lets the caller register a word in the same cycle its last byte arrives.
    assign o_word = i_shift ? w_shifted : r_word;
    assign o_last = (r_cnt == CW'(NBYTES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_word <= w_shifted;
            r_cnt  <= o_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/config_stream_loader.sv
// Parses SYNC/count/records/checksum byte frames into config_addr/config_data strobes.
// Latency: last data byte accepted in cycle t -> config_valid in cycle t+1.
// Backpressure: in_ready drops only in the one-cycle EMIT state; in_valid=0 stalls the parser.
module config_stream_loader
    import config_stream_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
    parameter int         ADDR_WIDTH = CFG_ADDR_WIDTH,
    parameter int         DATA_WIDTH = CFG_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] config_addr,
    output logic [DATA_WIDTH-1:0] config_data,
    output logic                  config_valid,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           records_loaded
);

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_in_ready;
    logic                  w_cfg_vld;
    logic                  w_accept;
    logic                  w_sync;
    logic                  w_addr_shift;
    logic                  w_data_shift;
    logic                  w_addr_last;
    logic                  w_data_last;
    logic [ADDR_WIDTH-1:0] w_addr_word;
    logic [DATA_WIDTH-1:0] w_data_word;

    logic [15:0]           r_count;
    logic [15:0]           r_rec;
    logic [7:0]            r_csum;
    logic                  r_done;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_cfg_addr;
    logic [DATA_WIDTH-1:0] r_cfg_data;

    assign w_accept     = in_valid && (r_state != ST_EMIT);
    assign w_sync       = (r_state == ST_IDLE) && w_accept && (in_data == SYNC_BYTE);
    assign w_addr_shift = (r_state == ST_ADDR) && w_accept;
    assign w_data_shift = (r_state == ST_DATA) && w_accept;

    stream_byte_shifter #(.WIDTH(ADDR_WIDTH)) u_addr_shifter (
        .clk     (clk),
        .reset   (reset),
        .i_shift (w_addr_shift),
        .i_clear (w_sync),
        .i_byte  (in_data),
        .o_word  (w_addr_word),
        .o_last  (w_addr_last)
    );

    stream_byte_shifter #(.WIDTH(DATA_WIDTH)) u_data_shifter (
        .clk     (clk),
        .reset   (reset),
        .i_shift (w_data_shift),
        .i_clear (w_sync),
        .i_byte  (in_data),
        .o_word  (w_data_word),
        .o_last  (w_data_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b1;
        w_cfg_vld    = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_sync) w_next_state = ST_LEN_LO;
            ST_LEN_LO: if (w_accept) w_next_state = ST_LEN_HI;
            ST_LEN_HI: if (w_accept) w_next_state = ({in_data, r_count[7:0]} != 16'd0) ? ST_ADDR : ST_CHECK;
            ST_ADDR:   if (w_accept && w_addr_last) w_next_state = ST_DATA;
            ST_DATA:   if (w_accept && w_data_last) w_next_state = ST_EMIT;
            ST_EMIT: begin
                w_in_ready   = 1'b0;
                w_cfg_vld    = 1'b1;
                w_next_state = ((r_rec + 16'd1) == r_count) ? ST_CHECK : ST_ADDR;
            end
            ST_CHECK:  if (w_accept) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_rec      <= '0;
            r_csum     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cfg_addr <= '0;
            r_cfg_data <= '0;
        end else begin
            if (w_sync) begin
                r_rec  <= '0;
                r_csum <= '0;
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (r_state == ST_LEN_LO && w_accept) r_count[7:0]  <= in_data;
            if (r_state == ST_LEN_HI && w_accept) r_count[15:8] <= in_data;
            if (w_addr_shift || w_data_shift) r_csum <= r_csum ^ in_data;
            if (w_data_shift && w_data_last) begin
                r_cfg_addr <= w_addr_word;
                r_cfg_data <= w_data_word;
            end
            if (r_state == ST_EMIT) r_rec <= r_rec + 16'd1;
            if (r_state == ST_CHECK && w_accept) begin
                r_done <= (in_data == r_csum);
                r_err  <= (in_data != r_csum);
            end
        end
    end

    assign in_ready       = w_in_ready;
    assign config_valid   = w_cfg_vld;
    assign config_addr    = r_cfg_addr;
    assign config_data    = r_cfg_data;
    assign load_done      = r_done;
    assign load_error     = r_err;
    assign records_loaded = r_rec;

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader; expected records are queued as frames are driven
// and popped by a monitor on each config_valid strobe.
module tb_config_stream_loader;
    import config_stream_loader_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_valid;
    logic        load_done;
    logic        load_error;
    logic [15:0] records_loaded;

    int n_checks = 0;
    int n_errors = 0;
    int strobes  = 0;
    logic [63:0] exp_q[$];
    logic [31:0] fa[4];
    logic [31:0] fd[4];

    config_stream_loader u_dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .config_addr    (config_addr),
        .config_data    (config_data),
        .config_valid   (config_valid),
        .load_done      (load_done),
        .load_error     (load_error),
        .records_loaded (records_loaded)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (config_valid) begin
            logic [63:0] e;
            strobes++;
            check("emit_in_ready", 64'(in_ready), 64'd0);
            check("strobe_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("strobe_addr", 64'(config_addr), 64'(e[63:32]));
                check("strobe_data", 64'(config_data), 64'(e[31:0]));
            end
        end
    end

    // Drives one byte; returns #1 after the accepting edge. With gap set, idles one cycle first.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int  cnt;
        bit  acc;
        cnt = 0;
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        acc = 1'b0;
        while (!acc && cnt < 20) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            cnt++;
        end
        in_valid = 1'b0;
        if (!acc) check("handshake_timeout", 64'(cnt), 64'd0);
    endtask

    task automatic send_frame(input int n, input bit stall, input bit force_csum, input logic [7:0] csum_val);
        logic [7:0] csum;
        logic [7:0] b;
        logic [15:0] cnt16;
        cnt16 = 16'(n);
        csum  = 8'h00;
        send_byte(8'hA5, stall);
        send_byte(cnt16[7:0], stall);
        send_byte(cnt16[15:8], stall);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({fa[i], fd[i]});
            for (int k = 0; k < 4; k++) begin
                b = fa[i][8*k +: 8];
                csum ^= b;
                send_byte(b, stall);
            end
            for (int k = 0; k < 4; k++) begin
                b = fd[i][8*k +: 8];
                csum ^= b;
                send_byte(b, stall);
            end
            check("strobe_latency", 64'(config_valid), 64'd1);
        end
        send_byte(force_csum ? csum_val : csum, stall);
    endtask

    initial begin
        int s0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",   64'(u_dut.r_state), 64'(ST_IDLE));
        check("rst_ready",   64'(in_ready), 64'd1);
        check("rst_valid",   64'(config_valid), 64'd0);
        check("rst_addr",    64'(config_addr), 64'd0);
        check("rst_data",    64'(config_data), 64'd0);
        check("rst_done",    64'(load_done), 64'd0);
        check("rst_error",   64'(load_error), 64'd0);
        check("rst_records", 64'(records_loaded), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset during the second data byte of a record.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hDD, 1'b0);
        send_byte(8'hCC, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst_state", 64'(u_dut.r_state), 64'(ST_IDLE));
        check("midrst_ready", 64'(in_ready), 64'd1);
        check("midrst_valid", 64'(config_valid), 64'd0);
        check("midrst_addr",  64'(config_addr), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_strobe", 64'(strobes), 64'd0);

        // Single record, good checksum.
        fa[0] = 32'h01020304;
        fd[0] = 32'hAABBCCDD;
        send_frame(1, 1'b0, 1'b0, 8'h00);
        check("single_strobes", 64'(strobes), 64'd1);
        check("single_records", 64'(records_loaded), 64'd1);
        check("single_done",    64'(load_done), 64'd1);
        check("single_error",   64'(load_error), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("hold_addr", 64'(config_addr), 64'h01020304);
        check("hold_data", 64'(config_data), 64'hAABBCCDD);
        check("hold_done", 64'(load_done), 64'd1);

        // Same frame with a wrong checksum byte.
        send_frame(1, 1'b0, 1'b1, 8'h5A);
        check("bad_strobes", 64'(strobes), 64'd2);
        check("bad_error",   64'(load_error), 64'd1);
        check("bad_done",    64'(load_done), 64'd0);

        // Zero-count frame; the SYNC byte clears the sticky error first.
        send_byte(8'hA5, 1'b0);
        check("sync_clears_error", 64'(load_error), 64'd0);
        check("sync_clears_recs",  64'(records_loaded), 64'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check("zero_state", 64'(u_dut.r_state), 64'(ST_CHECK));
        send_byte(8'h00, 1'b0);
        check("zero_strobes", 64'(strobes), 64'd2);
        check("zero_done",    64'(load_done), 64'd1);

        // Three records with in_valid toggling every cycle.
        fa[0] = 32'h10000001; fd[0] = 32'hA5A5A5A5;
        fa[1] = 32'h200000FF; fd[1] = 32'h00000000;
        fa[2] = 32'hDEADBEEF; fd[2] = 32'h12345678;
        s0 = strobes;
        send_frame(3, 1'b1, 1'b0, 8'h00);
        check("stall_strobes", 64'(strobes - s0), 64'd3);
        check("stall_records", 64'(records_loaded), 64'd3);
        check("stall_done",    64'(load_done), 64'd1);

        // Garbage ahead of the SYNC byte.
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h12, 1'b0);
        check("garbage_idle", 64'(u_dut.r_state), 64'(ST_IDLE));
        fa[0] = 32'hCAFEF00D;
        fd[0] = 32'h0BADBEEF;
        s0 = strobes;
        send_frame(1, 1'b0, 1'b0, 8'h00);
        check("garbage_strobes", 64'(strobes - s0), 64'd1);
        check("garbage_done",    64'(load_done), 64'd1);
        check("garbage_error",   64'(load_error), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
